// File: rtl/kalman_pkg.sv
// kalman_pkg: shared state encoding and bank-mux widths for the Kalman sequencer and its neighbours
package kalman_pkg;
    localparam int DW = 32;
    localparam int N_STATE = 6;
    localparam int N_MEAS = 4;
    typedef enum logic [2:0] {S_IDLE, S_PREDICT, S_GAIN, S_UPDATE, S_WB} state_t;
endpackage

// File: rtl/kalman_sched_rr_arbiter.sv
// rr_arbiter: combinational first-set search upward from a rotating pointer
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CHW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [CHW-1:0]    ptr,
    output logic [CHW-1:0]    grant,
    output logic              any_valid
);
    function automatic int wrap(input int j);
        return j >= NUM_CH ? j - NUM_CH : j;
    endfunction
    // scan from farthest to nearest so the nearest set bit at or above ptr is the last one written
    always_comb begin
        grant = '0;
        any_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (pend[CHW'(wrap(int'(ptr) + k))]) begin
                grant = CHW'(wrap(int'(ptr) + k));
                any_valid = 1'b1;
            end
    end
endmodule

// File: rtl/kalman_sched.sv
// kalman_sched: round-robin sequencer sharing one predict/gain/update engine across NUM_CH tracks
import kalman_pkg::*;
module kalman_sched #(
    parameter int NUM_CH = 4,
    parameter int CHW = $clog2(NUM_CH),
    parameter int TIMEOUT = 4096,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] req_meas,
    input  logic              clr_ovr,
    output logic [CHW-1:0]    cur_ch,
    output logic              busy,
    output logic              predict_start,
    output logic              gain_start,
    output logic              update_start,
    input  logic              predict_done,
    input  logic              gain_done,
    input  logic              update_done,
    output logic              wb_en,
    output logic              wb_sel,
    output logic              done_valid,
    output logic [CHW-1:0]    done_ch,
    output logic              done_err,
    output logic [NUM_CH-1:0] ovr_flags,
    output logic [CNTW-1:0]   iter_cnt,
    output logic [CNTW-1:0]   err_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t state, state_nx;
    logic [NUM_CH-1:0] pend, mflag, gmask;
    logic [CHW-1:0] ptr, win;
    logic [TW-1:0] timer;
    logic any_valid, mode, grant, phase, done_ok;
    logic ps_nx, gs_nx, us_nx, wb_nx, sel_nx, dv_nx, de_nx;

    rr_arbiter #(.NUM_CH(NUM_CH), .CHW(CHW)) u_arb (
        .pend(pend), .ptr(ptr), .grant(win), .any_valid(any_valid)
    );

    assign busy = state != S_IDLE;
    assign phase = state == S_PREDICT || state == S_GAIN || state == S_UPDATE;
    // a done is ignored in its start cycle so a level still held from the previous phase cannot complete it
    assign done_ok = (state == S_PREDICT && predict_done && !predict_start) ||
                     (state == S_GAIN && gain_done && !gain_start) ||
                     (state == S_UPDATE && update_done && !update_start);
    assign gmask = {{(NUM_CH - 1){1'b0}}, grant} << win;

    // next state, start pulses and completion strobes; done beats a coincident timeout
    always_comb begin
        state_nx = state;
        grant = 1'b0;
        ps_nx = 1'b0;
        gs_nx = 1'b0;
        us_nx = 1'b0;
        wb_nx = 1'b0;
        dv_nx = 1'b0;
        de_nx = 1'b0;
        sel_nx = wb_sel;
        case (state)
            S_IDLE: if (en && any_valid) begin
                grant = 1'b1;
                ps_nx = 1'b1;
                state_nx = S_PREDICT;
            end
            S_PREDICT: if (done_ok) begin
                gs_nx = mode;
                wb_nx = !mode;
                dv_nx = !mode;
                sel_nx = mode ? wb_sel : 1'b0;
                state_nx = mode ? S_GAIN : S_WB;
            end
            S_GAIN: if (done_ok) begin
                us_nx = 1'b1;
                state_nx = S_UPDATE;
            end
            S_UPDATE: if (done_ok) begin
                wb_nx = 1'b1;
                dv_nx = 1'b1;
                sel_nx = 1'b1;
                state_nx = S_WB;
            end
            default: state_nx = S_IDLE;
        endcase
        if (phase && !done_ok && timer == T_LAST) begin
            dv_nx = 1'b1;
            de_nx = 1'b1;
            state_nx = S_IDLE;
        end
    end

    // state register, registered engine/bank strobes, grant bookkeeping and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            {predict_start, gain_start, update_start, wb_en, wb_sel, done_valid, done_err} <= '0;
            cur_ch <= '0;
            done_ch <= '0;
            ptr <= '0;
            mode <= 1'b0;
            timer <= '0;
            iter_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            predict_start <= ps_nx;
            gain_start <= gs_nx;
            update_start <= us_nx;
            wb_en <= wb_nx;
            wb_sel <= sel_nx;
            done_valid <= dv_nx;
            done_err <= de_nx;
            timer <= (state_nx != state || !phase) ? '0 : timer + 1'b1;
            if (dv_nx) done_ch <= cur_ch;
            if (grant) begin
                cur_ch <= win;
                mode <= mflag[win];
                ptr <= (win == CHW'(NUM_CH - 1)) ? '0 : win + 1'b1;
            end
            if (state == S_WB) iter_cnt <= iter_cnt + 1'b1;
            if (de_nx && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
        end
    end

    // pending capture: a new request beats the grant clear, and overrun set beats clr_ovr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            mflag <= '0;
            ovr_flags <= '0;
        end else begin
            pend <= (pend & ~gmask) | req;
            mflag <= (mflag & ~req) | (req & req_meas);
            ovr_flags <= (clr_ovr ? '0 : ovr_flags) | (req & pend);
        end
    end
endmodule

// File: doc/kalman_sched.md
Name: kalman_sched

Overview:
- Multi-channel sequencer for the Kalman predict/gain/update datapath. It time-shares one predict, gain and update engine across NUM_CH independent tracks.
- Upstream issues per-channel iteration requests. The block arbitrates them round-robin and sequences the engine phases with single-cycle start pulses.
- Per request it performs either a full iteration or a predict-only iteration (no measurement that epoch).
- It drives the external per-channel x/P state-bank writeback, and flags phase timeouts and request overruns.

Parameters:
- NUM_CH, 4, number of tracks (2..16).
- CHW, $clog2(NUM_CH), channel index width (derived).
- TIMEOUT, 4096, max cycles in any one phase before abort.
- CNTW, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  enables new grants; low lets the in-flight iteration finish, then holds IDLE
- req  in  NUM_CH  per-channel one-cycle iteration request
- req_meas  in  NUM_CH  qualifies req: 1 = measurement available (full iteration), 0 = predict-only
- clr_ovr  in  1  clears ovr_flags
- cur_ch  out  CHW  channel currently granted; selects the state-bank/z mux
- busy  out  1  high in any state except IDLE
- predict_start, gain_start, update_start  out  1  single-cycle engine start pulses
- predict_done, gain_done, update_done  in  1  engine completion (level or pulse)
- wb_en  out  1  one-cycle state-bank write strobe for cur_ch
- wb_sel  out  1  0 = write predict results (xhat/Phat), 1 = write update results
- done_valid  out  1  one-cycle iteration-complete pulse
- done_ch  out  CHW  channel of done_valid
- done_err  out  1  qualifies done_valid: iteration aborted by timeout
- ovr_flags  out  NUM_CH  sticky per-channel overrun
- iter_cnt  out  CNTW  completed good iterations, wraps
- err_cnt  out  CNTW  aborted iterations, saturates at all-ones

Behaviour:
- Reset: all outputs 0; pending and meas bits 0; RR pointer 0; state IDLE; phase timer 0.
- Pending capture:
  - req[i] sets pend[i] and loads mflag[i] = req_meas[i] (latest request wins).
  - req[i] while pend[i] is already set sets ovr_flags[i].
  - req[i] for the channel in service sets pend[i] again; it is served in a later round.
  - A request arriving in the same cycle as the grant clear of that channel also wins and re-sets pend.
- clr_ovr: clears ovr_flags. A simultaneous new overrun sets its bit, because set has priority over clear.
- States: IDLE, PREDICT, GAIN, UPDATE, WB.
- IDLE:
  - If en and any pend bit is set: grant the first set bit searching upward from the RR pointer, wrapping modulo NUM_CH.
  - On grant: cur_ch <= winner; pend[winner] <= 0; mode <= mflag[winner]; RR pointer <= winner+1 mod NUM_CH; predict_start pulses next cycle; state -> PREDICT.
  - Latency: req at cycle t gives predict_start at t+2 when the block is idle.
- Done sampling: a done input is accepted only while in its matching state, and never in the cycle its start pulse is high. This guards against stale level-held done.
- PREDICT: on predict_done, go to GAIN with a gain_start pulse if mode=1; otherwise go to WB with wb_sel=0.
- GAIN: on gain_done, go to UPDATE with an update_start pulse.
- UPDATE: on update_done, go to WB with wb_sel=1.
- WB (one cycle):
  - wb_en=1, done_valid=1, done_ch=cur_ch, done_err=0; iter_cnt++; return to IDLE.
  - A new grant is possible on the following cycle.
- Timeout:
  - The phase timer clears on every phase entry and increments each cycle in PREDICT, GAIN or UPDATE.
  - Reaching TIMEOUT-1 without done: done_valid=1, done_err=1, wb_en=0, err_cnt++ (saturating), go to IDLE.
  - A done arriving in the same cycle as timeout: done wins.
- en: deasserting mid-iteration does not abort the iteration. pend bits keep accumulating.
- cur_ch holds its last value in IDLE.
- Reset mid-operation: immediate return to reset values. Pending requests are lost, and no done_valid is issued for the interrupted channel.

Decomposition:
- Shared package kalman_pkg holds:
  - state encoding constants (S_IDLE..S_WB);
  - Q20.12 word width constant DW=32 plus N_STATE=6 and N_MEAS=4, for the bank mux widths used by neighbouring blocks.
- Sub-module rr_arbiter (NUM_CH): combinational first-set search from the pointer, outputs grant index and any_valid. The FSM owns the pointer register.

Test Plan:
- Single full iteration, NUM_CH=4: req=0b0100, req_meas=0b0100, engines done 5 cycles after each start -> predict_start at t+2, cur_ch=2, gain and update starts in order, wb_en=1 with wb_sel=1, done_valid with done_ch=2, iter_cnt=1.
- Predict-only: req=0b0001, req_meas=0 -> no gain_start or update_start; wb_sel=0; done_ch=0.
- Round-robin: req=0b1111 in one cycle -> grant order 0,1,2,3; then req=0b1001 -> order 0,3.
- Overrun: req[1] twice while channel 1 is pending behind channel 0 -> ovr_flags=0b0010; channel 1 served once. clr_ovr and a new overrun in the same cycle -> flag stays set.
- Timeout with TIMEOUT=16: gain_done never asserts -> done_valid with done_err=1 exactly 16 cycles after GAIN entry, wb_en=0, err_cnt=1. done in the timeout cycle -> normal completion.
- Reset mid-UPDATE and en low: rst asserted -> all outputs 0 asynchronously. With en=0 and pend set, the block stays IDLE; raising en grants next cycle.
